i2s_rec_deserializer: RTL and testbench



---
 rtl/i2s_rec_deserializer_if.sv | 28 ++
 rtl/i2s_rec_deserializer.sv | 191 +++++++++++++++++++
 tb/tb_i2s_rec_deserializer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rec_deserializer_if.sv
// Stream interface for captured I2S record samples.
//   m_tdata  : captured sample word, MSB-first order from the codec
//   m_tuser  : channel tag, 0 = left, 1 = right
//   m_tvalid : a sample is available at the head of the buffer
//   m_tready : consumer accepts the current sample
// The master modport is the deserializer side; slave is the consumer side.
interface i2s_rec_deserializer_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tuser;
  logic                  m_tvalid;
  logic                  m_tready;

  modport master (
    output m_tdata,
    output m_tuser,
    output m_tvalid,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tuser,
    input  m_tvalid,
    output m_tready
  );
endinterface

// File: rtl/i2s_rec_deserializer.sv
// I2S master receiver for the codec record path.
// Generates BCLK and RECLRCLK from clk, shifts RECDAT in MSB first with the
// usual one-BCLK delay after each word-select change, and hands finished
// left/right samples to a stream consumer through a small show-ahead FIFO.
// Ports:
//   clk       : fabric clock
//   resetn    : synchronous active-low reset
//   enable    : 1 runs the serial interface, 0 parks it (FIFO kept)
//   BCLK      : codec bit clock, period 2*CLK_DIV clk cycles
//   RECLRCLK  : word select, 0 = left slot, 1 = right slot
//   RECDAT    : serial data from codec, sampled on BCLK rise
//   m_axis    : sample stream (tdata/tuser/tvalid/tready)
//   overflow  : sticky flag, a finished sample was dropped on a full FIFO
//   clear_ovf : clears overflow on the next edge
module i2s_rec_deserializer #(
  parameter int CLK_DIV    = 8,
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  output logic                          BCLK,
  output logic                          RECLRCLK,
  input  logic                          RECDAT,
  i2s_rec_deserializer_if.master        m_axis,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W = DATA_WIDTH + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'(SLOT_BITS - 1);
  localparam logic [4:0]       BIT_DATA = 5'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]      div_cnt;
  logic [4:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  running;
  logic                  tick;
  logic                  rise_evt;
  logic                  fall_evt;
  logic                  capture;
  logic                  last_bit;

  logic                  push_pending;
  logic [WORD_W-1:0]     push_word;

  logic [WORD_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  valid;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;
  logic                  drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Run/idle control
  // ---------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before any branch,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Divider / slot events
  // ---------------------------------------------------------------------
  always_comb begin
    running   = (state == RUN) && enable;
    tick      = running && (div_cnt == DIV_LAST);
    rise_evt  = tick && !BCLK;
    fall_evt  = tick && BCLK;
    // bit_cnt 0 is the one-BCLK delay slot; data occupies 1..DATA_WIDTH.
    capture   = rise_evt && (bit_cnt != 5'd0) && (bit_cnt <= BIT_DATA);
    last_bit  = rise_evt && (bit_cnt == BIT_DATA);
    shift_nxt = DATA_WIDTH'({shift_reg, RECDAT});
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      BCLK         <= 1'b0;
      RECLRCLK     <= 1'b0;
      shift_reg    <= '0;
      push_pending <= 1'b0;
      push_word    <= '0;
    end else begin
      if (running) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) BCLK <= ~BCLK;
        if (fall_evt) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            RECLRCLK <= ~RECLRCLK;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        if (capture) shift_reg <= shift_nxt;
      end else begin
        // Idle or aborting: park the pins and throw away any partial word.
        div_cnt   <= '0;
        bit_cnt   <= '0;
        BCLK      <= 1'b0;
        RECLRCLK  <= 1'b0;
        shift_reg <= '0;
      end
      // A completed word is registered here and written one edge later,
      // even if enable drops in between.
      push_pending <= last_bit;
      push_word    <= {RECLRCLK, shift_nxt};
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------
  always_comb begin
    valid   = (count != '0);
    full    = (count == CNT_FULL);
    do_pop  = valid && m_axis.m_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push_pending && (!full || do_pop);
    drop    = push_pending && full && !do_pop;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A drop beats a simultaneous clear so no loss goes unreported.
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; the occupancy count
  // defines which entries are meaningful, and the outputs are gated below.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  assign m_axis.m_tvalid = valid;
  assign m_axis.m_tdata  = valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign m_axis.m_tuser  = valid ? mem[rd_ptr][DATA_WIDTH]     : 1'b0;

endmodule

// File: tb/tb_i2s_rec_deserializer.sv
// Self-checking bench for i2s_rec_deserializer.
// A timeline model (time since RUN entry -> BCLK, RECLRCLK, push instants)
// plus a queue-based FIFO model is compared against the DUT on every falling
// clk edge; directed literal checks pin the model at key instants.
module tb_i2s_rec_deserializer;

  localparam int CLK_DIV  = 2;
  localparam int DW       = 24;
  localparam int DEPTH    = 4;
  localparam int SLOT     = 32;
  localparam int BCLK_CLK = 2 * CLK_DIV;
  localparam int SLOT_CLK = BCLK_CLK * SLOT;
  // Edge (time since RUN entry within a slot) at which the finished word
  // lands in the FIFO: one clk after the rise that carries the last bit.
  localparam int PUSH_T   = CLK_DIV * (2 * DW + 1) + 1;

  logic clk = 1'b0;
  logic resetn;
  logic enable;
  logic RECDAT;
  logic clear_ovf;
  logic BCLK;
  logic RECLRCLK;
  logic overflow;

  i2s_rec_deserializer_if #(.DATA_WIDTH(DW)) axis ();

  i2s_rec_deserializer #(
    .CLK_DIV   (CLK_DIV),
    .DATA_WIDTH(DW),
    .SLOT_BITS (SLOT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .BCLK     (BCLK),
    .RECLRCLK (RECLRCLK),
    .RECDAT   (RECDAT),
    .m_axis   (axis),
    .overflow (overflow),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int entry   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] words [16] = '{
    24'hA5C3F0, 24'h123456, 24'h800001, 24'h7FFFFE,
    24'h000000, 24'hFFFFFF, 24'h5A5A5A, 24'hC0FFEE,
    24'h135795, 24'h2468AC, 24'h0F0F0F, 24'hF0F0F0,
    24'h000001, 24'h800000, 24'hABCDEF, 24'h654321
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance until rel clk edges after RUN entry have happened, then step off the edge.
  task automatic wait_rel(input int rel);
    while (cyc < entry + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------
  // Model + codec + per-cycle compare
  // ---------------------------------------------------------------------
  logic [DW:0]   q[$];
  logic [DW:0]   popped[$];
  bit            m_run    = 1'b0;
  int            m_t      = 0;
  bit            m_ovf    = 1'b0;
  int            slot_seq = 0;
  logic [DW-1:0] cur_word = '0;

  initial begin
    int          exp_bclk;
    int          exp_lr;
    int          idx;
    bit          do_pop;
    bit          do_push;
    bit          dropped;
    logic [DW:0] new_word;
    RECDAT = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_bclk = m_run ? (m_t / CLK_DIV) % 2 : 0;
      exp_lr   = m_run ? (m_t / SLOT_CLK) % 2 : 0;
      check("BCLK", 32'(BCLK), 32'(exp_bclk));
      check("RECLRCLK", 32'(RECLRCLK), 32'(exp_lr));
      check("m_tvalid", 32'(axis.m_tvalid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("m_tdata", 32'(axis.m_tdata), 32'(q[0][DW-1:0]));
        check("m_tuser", 32'(axis.m_tuser), 32'(q[0][DW]));
      end
      check("overflow", 32'(overflow), 32'(m_ovf));

      // What the next edge does, from the inputs now being applied.
      do_pop   = (q.size() != 0) && (axis.m_tready == 1'b1);
      do_push  = m_run && ((m_t % SLOT_CLK) == PUSH_T - 1);
      new_word = {1'((m_t / SLOT_CLK) % 2), cur_word};
      dropped  = 1'b0;
      if (!resetn) begin
        q.delete();
        m_ovf = 1'b0;
        m_run = 1'b0;
        m_t   = 0;
      end else begin
        if (do_pop) begin
          popped.push_back(q[0]);
          void'(q.pop_front());
        end
        if (do_push) begin
          if (q.size() < DEPTH) q.push_back(new_word);
          else begin
            m_ovf   = 1'b1;
            dropped = 1'b1;
          end
        end
        if (clear_ovf && !dropped) m_ovf = 1'b0;
        if (!m_run) begin
          if (enable) begin
            m_run    = 1'b1;
            m_t      = 0;
            cur_word = words[slot_seq % 16];
            slot_seq++;
          end
        end else if (!enable) begin
          m_run = 1'b0;
        end else begin
          m_t++;
          if (m_t % SLOT_CLK == 0) begin
            cur_word = words[slot_seq % 16];
            slot_seq++;
          end
        end
      end

      // Codec: present the data bit only where a rise samples it; noise elsewhere.
      idx = ((m_t % SLOT_CLK) - CLK_DIV) / BCLK_CLK;
      if (!m_run)
        RECDAT = 1'b1;
      else if ((m_t % BCLK_CLK == CLK_DIV) && idx >= 1 && idx <= DW)
        RECDAT = cur_word[DW-idx];
      else
        RECDAT = 1'($urandom);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed stimulus and literal checks
  // ---------------------------------------------------------------------
  initial begin
    int exp_idx [7] = '{0, 1, 2, 3, 4, 5, 7};
    resetn        = 1'b0;
    enable        = 1'b1;
    clear_ovf     = 1'b0;
    axis.m_tready = 1'b0;

    // Reset dominates enable and RECDAT.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_BCLK", 32'(BCLK), 32'd0);
      check("rst_RECLRCLK", 32'(RECLRCLK), 32'd0);
      check("rst_m_tvalid", 32'(axis.m_tvalid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
    end

    // Release with enable high: RUN entry on the next edge.
    resetn        = 1'b1;
    axis.m_tready = 1'b1;
    entry         = cyc + 1;

    wait_rel(1);   check("bclk_t1", 32'(BCLK), 32'd0);
    wait_rel(2);   check("bclk_first_rise", 32'(BCLK), 32'd1);
    wait_rel(4);   check("bclk_first_fall", 32'(BCLK), 32'd0);
    wait_rel(98);  check("left_not_yet", 32'(axis.m_tvalid), 32'd0);
    wait_rel(99);
    check("left_valid", 32'(axis.m_tvalid), 32'd1);
    check("left_data", 32'(axis.m_tdata), 32'h00A5C3F0);
    check("left_user", 32'(axis.m_tuser), 32'd0);
    wait_rel(127); check("lr_before", 32'(RECLRCLK), 32'd0);
    wait_rel(128); check("lr_toggle", 32'(RECLRCLK), 32'd1);
    wait_rel(227);
    check("right_valid", 32'(axis.m_tvalid), 32'd1);
    check("right_data", 32'(axis.m_tdata), 32'h00123456);
    check("right_user", 32'(axis.m_tuser), 32'd1);

    // Backpressure: slots 2..5 fill the FIFO, slot 6 is dropped.
    wait_rel(230); axis.m_tready = 1'b0;
    wait_rel(866); check("ovf_before", 32'(overflow), 32'd0);
    wait_rel(867);
    check("ovf_set", 32'(overflow), 32'd1);
    check("held_head", 32'(axis.m_tdata), 32'h00800001);
    wait_rel(870); clear_ovf = 1'b1;
    wait_rel(871);
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, pop in the very cycle of the slot-7 push.
    wait_rel(994); axis.m_tready = 1'b1;
    wait_rel(995);
    axis.m_tready = 1'b0;
    check("fullpp_ovf", 32'(overflow), 32'd0);
    check("fullpp_head", 32'(axis.m_tdata), 32'h007FFFFE);
    wait_rel(1000); axis.m_tready = 1'b1;
    wait_rel(1004);
    check("drained", 32'(axis.m_tvalid), 32'd0);
    check("pop_count", 32'(popped.size()), 32'd7);
    for (int i = 0; i < 7 && i < popped.size(); i++)
      check("pop_order", 32'(popped[i]), 32'({1'(exp_idx[i] % 2), words[exp_idx[i]]}));

    // Abort in the right slot with bit_cnt = 10.
    wait_rel(1194);
    check("abort_pre_bclk", 32'(BCLK), 32'd1);
    check("abort_pre_lr", 32'(RECLRCLK), 32'd1);
    enable = 1'b0;
    wait_rel(1195);
    check("abort_bclk", 32'(BCLK), 32'd0);
    check("abort_lr", 32'(RECLRCLK), 32'd0);
    wait_rel(1205);
    check("abort_no_word", 32'(axis.m_tvalid), 32'd0);
    check("abort_pops", 32'(popped.size()), 32'd8);

    // Re-enable: first word is a left sample; queue three then reset.
    enable        = 1'b1;
    axis.m_tready = 1'b0;
    entry         = cyc + 1;
    wait_rel(99);
    check("reen_valid", 32'(axis.m_tvalid), 32'd1);
    check("reen_user", 32'(axis.m_tuser), 32'd0);
    check("reen_data", 32'(axis.m_tdata), 32'h000F0F0F);
    wait_rel(360);
    check("queued_valid", 32'(axis.m_tvalid), 32'd1);
    resetn = 1'b0;
    wait_rel(361);
    check("rst_q_valid", 32'(axis.m_tvalid), 32'd0);
    check("rst_q_data", 32'(axis.m_tdata), 32'd0);
    check("rst_q_bclk", 32'(BCLK), 32'd0);
    resetn = 1'b1;
    enable = 1'b0;
    wait_rel(365);
    check("idle_valid", 32'(axis.m_tvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
